// File: rtl/decryption_fsm.sv
// rtl/decryption_fsm.sv - AES inverse-cipher control FSM (optional abort via AES_DEC_ABORT_EN)
module decryption_fsm #(
  parameter int NR            = 10,
  parameter int CYC_PER_ROUND = 3,
  parameter int KAW           = 4
) (
  input  logic           clk,
  input  logic           reset_n,
  input  logic           start,
  input  logic           key_ready,
`ifdef AES_DEC_ABORT_EN
  input  logic           abort,
`endif
  output logic           busy,
  output logic           key_rd_en,
  output logic [KAW-1:0] key_addr,
  output logic           ld_sel,
  output logic           st_en,
  output logic           mc_bypass,
  output logic           done
);

  localparam int CW = (CYC_PER_ROUND > 2) ? $clog2(CYC_PER_ROUND) : 1;

  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_KEY_WAIT = 3'd1;
  localparam logic [2:0] S_INIT     = 3'd2;
  localparam logic [2:0] S_MID      = 3'd3;
  localparam logic [2:0] S_LAST     = 3'd4;

  localparam logic [KAW-1:0] RC_TOP  = KAW'(NR);
  localparam logic [KAW-1:0] RC_MID  = KAW'(NR - 1);
  localparam logic [CW-1:0]  CYC_TOP = CW'(CYC_PER_ROUND - 1);

  logic [2:0]     state_q, state_d;
  logic [KAW-1:0] rc_q, rc_d;
  logic [CW-1:0]  cyc_q, cyc_d;
  logic [KAW-1:0] addr_q;
  logic           done_q, done_d;
  logic           abort_w;

`ifdef AES_DEC_ABORT_EN
  assign abort_w = abort & (state_q != S_IDLE);
`else
  assign abort_w = 1'b0;
`endif

  // Strobe decode: read key on the first cycle of a round, write state on the last
  always_comb begin
    busy      = (state_q != S_IDLE);
    key_rd_en = 1'b0;
    st_en     = 1'b0;
    ld_sel    = 1'b0;
    mc_bypass = 1'b0;
    case (state_q)
      S_INIT: begin
        key_rd_en = (cyc_q == CW'(1));
        st_en     = (cyc_q == '0);
      end
      S_MID: begin
        key_rd_en = (cyc_q == CYC_TOP);
        st_en     = (cyc_q == '0);
        ld_sel    = (cyc_q == '0);
      end
      S_LAST: begin
        key_rd_en = (cyc_q == CYC_TOP);
        st_en     = (cyc_q == '0);
        ld_sel    = (cyc_q == '0);
        mc_bypass = 1'b1;
      end
      default: ;
    endcase
    if (abort_w) begin
      key_rd_en = 1'b0;
      st_en     = 1'b0;
      ld_sel    = 1'b0;
    end
    key_addr = key_rd_en ? rc_q : addr_q;
  end

  // Next-state and counter sequencing; round_cnt doubles as the key index
  always_comb begin
    state_d = state_q;
    rc_d    = rc_q;
    cyc_d   = cyc_q;
    done_d  = 1'b0;
    case (state_q)
      S_IDLE: begin
        rc_d  = RC_TOP;
        cyc_d = '0;
        if (start) begin
          if (key_ready) begin
            state_d = S_INIT;
            cyc_d   = CW'(1);
          end else begin
            state_d = S_KEY_WAIT;
          end
        end
      end
      S_KEY_WAIT: begin
        if (key_ready) begin
          state_d = S_INIT;
          cyc_d   = CW'(1);
        end
      end
      S_INIT: begin
        if (cyc_q == '0) begin
          state_d = S_MID;
          rc_d    = RC_MID;
          cyc_d   = CYC_TOP;
        end else begin
          cyc_d = cyc_q - CW'(1);
        end
      end
      S_MID: begin
        if (cyc_q == '0) begin
          rc_d  = rc_q - KAW'(1);
          cyc_d = CYC_TOP;
          if (rc_q == KAW'(1)) state_d = S_LAST;
        end else begin
          cyc_d = cyc_q - CW'(1);
        end
      end
      S_LAST: begin
        if (cyc_q == '0) begin
          state_d = S_IDLE;
          rc_d    = RC_TOP;
          done_d  = 1'b1;
        end else begin
          cyc_d = cyc_q - CW'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
    if (abort_w) begin
      state_d = S_IDLE;
      rc_d    = RC_TOP;
      cyc_d   = '0;
      done_d  = 1'b0;
    end
  end

  // State, counters, held key address and registered done pulse
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      rc_q    <= RC_TOP;
      cyc_q   <= '0;
      addr_q  <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      rc_q    <= rc_d;
      cyc_q   <= cyc_d;
      done_q  <= done_d;
      if (key_rd_en) addr_q <= key_addr;
    end
  end

  assign done = done_q;

endmodule

// File: tb/tb_decryption_fsm.sv
// tb/tb_decryption_fsm.sv - directed-vector bench for decryption_fsm
module tb_decryption_fsm;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset_n, start, key_ready, start2, key_ready2;
`ifdef AES_DEC_ABORT_EN
  logic abort, abort2;
`endif

  logic a_busy, a_rd, a_ld, a_st, a_mc, a_done;
  logic b_busy, b_rd, b_ld, b_st, b_mc, b_done;
  logic [3:0] a_addr, b_addr;

  decryption_fsm #(.NR(10), .CYC_PER_ROUND(3), .KAW(4)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .key_ready(key_ready),
`ifdef AES_DEC_ABORT_EN
    .abort(abort),
`endif
    .busy(a_busy), .key_rd_en(a_rd), .key_addr(a_addr), .ld_sel(a_ld),
    .st_en(a_st), .mc_bypass(a_mc), .done(a_done)
  );

  decryption_fsm #(.NR(14), .CYC_PER_ROUND(2), .KAW(4)) dut14 (
    .clk(clk), .reset_n(reset_n), .start(start2), .key_ready(key_ready2),
`ifdef AES_DEC_ABORT_EN
    .abort(abort2),
`endif
    .busy(b_busy), .key_rd_en(b_rd), .key_addr(b_addr), .ld_sel(b_ld),
    .st_en(b_st), .mc_bypass(b_mc), .done(b_done)
  );

  bit sel;
  logic o_busy, o_rd, o_ld, o_st, o_mc, o_done;
  logic [3:0] o_addr;
  always_comb begin
    if (sel) begin
      o_busy = b_busy; o_rd = b_rd; o_ld = b_ld; o_st = b_st;
      o_mc = b_mc; o_done = b_done; o_addr = b_addr;
    end else begin
      o_busy = a_busy; o_rd = a_rd; o_ld = a_ld; o_st = a_st;
      o_mc = a_mc; o_done = a_done; o_addr = a_addr;
    end
  end

  int nvec = 0;
  int nbad = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nvec++;
    if (obs !== exp) begin
      nbad++;
      $display("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  int rd_a[$];
  int rd_e[$];
  int st_e[$];
  int st_ld[$];
  int mc_cnt, busy_cnt, done_edge, pre_strobe;

  // k counts edges from E0 (the edge that samples start); observations taken at negedge
  task automatic run_op(input int kr_rise, input bit hold, input int limit);
    rd_a.delete(); rd_e.delete(); st_e.delete(); st_ld.delete();
    mc_cnt = 0; busy_cnt = 0; done_edge = -1; pre_strobe = 0;
    if (sel) start2 = 1'b1; else start = 1'b1;
    for (int k = 0; k < limit; k++) begin
      @(posedge clk);
      @(negedge clk);
      if (!hold) begin start = 1'b0; start2 = 1'b0; end
      if (o_busy) busy_cnt++;
      if (o_rd) begin rd_a.push_back(int'(o_addr)); rd_e.push_back(k); end
      if (o_st) begin st_e.push_back(k); st_ld.push_back(int'(o_ld)); end
      if (o_mc) mc_cnt++;
      if (k < kr_rise && (o_rd || o_st)) pre_strobe++;
      if (k == kr_rise - 1) key_ready = 1'b1;
      if (o_done) begin done_edge = k; break; end
    end
  endtask

  task automatic check_op(input string tag, input int nr, input int cyc, input int exp_done);
    int ldsum;
    chk({tag, "/done_edge"}, done_edge, exp_done);
    chk({tag, "/busy_cycles"}, busy_cnt, exp_done);
    chk({tag, "/rd_count"}, rd_a.size(), nr + 1);
    chk({tag, "/st_count"}, st_e.size(), nr + 1);
    for (int i = 0; i < rd_a.size(); i++)
      chk($sformatf("%s/key_addr%0d", tag, i), rd_a[i], nr - i);
    for (int i = 0; i < rd_e.size() && i < st_e.size(); i++)
      chk($sformatf("%s/rd_to_st%0d", tag, i), st_e[i] - rd_e[i], (i == 0) ? 1 : cyc - 1);
    ldsum = 0;
    foreach (st_ld[i]) ldsum += st_ld[i];
    if (st_ld.size() > 0) chk({tag, "/first_ld_sel"}, st_ld[0], 0);
    chk({tag, "/ld_sel_count"}, ldsum, nr);
    chk({tag, "/mc_bypass_cycles"}, mc_cnt, cyc);
  endtask

  task automatic idle_check(input string tag);
    @(negedge clk);
    chk({tag, "/done_pulse_width"}, o_done, 0);
    chk({tag, "/busy_after"}, o_busy, 0);
  endtask

  initial begin
    bit found;
    reset_n = 1'b0; start = 1'b0; start2 = 1'b0;
    key_ready = 1'b1; key_ready2 = 1'b1; sel = 1'b0;
`ifdef AES_DEC_ABORT_EN
    abort = 1'b0; abort2 = 1'b0;
`endif
    repeat (3) @(negedge clk);
    chk("reset/outs_a", {a_busy, a_rd, a_ld, a_st, a_mc, a_done, a_addr}, 0);
    chk("reset/outs_b", {b_busy, b_rd, b_ld, b_st, b_mc, b_done, b_addr}, 0);
    reset_n = 1'b1;
    @(negedge clk);

    run_op(0, 1'b0, 60);
    check_op("base", 10, 3, 32);
    idle_check("base");

    key_ready = 1'b0;
    run_op(5, 1'b0, 60);
    check_op("keywait", 10, 3, 37);
    chk("keywait/no_strobes", pre_strobe, 0);
    idle_check("keywait");

    run_op(0, 1'b1, 60);
    check_op("b2b_1", 10, 3, 32);
    run_op(0, 1'b0, 60);
    check_op("b2b_2", 10, 3, 32);
    idle_check("b2b");

    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    found = 1'b0;
    for (int k = 0; k < 40 && !found; k++) begin
      @(negedge clk);
      if (a_rd && a_addr == 4'd5) found = 1'b1;
    end
    chk("rst_mid/reached_round5", found, 1);
    reset_n = 1'b0;
    #1;
    chk("rst_mid/outs_zero", {a_busy, a_rd, a_ld, a_st, a_mc, a_done, a_addr}, 0);
    found = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      if (a_done) found = 1'b1;
    end
    reset_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      if (a_done || a_busy) found = 1'b1;
    end
    chk("rst_mid/no_done", found, 0);
    run_op(0, 1'b0, 60);
    check_op("after_rst", 10, 3, 32);
    idle_check("after_rst");

`ifdef AES_DEC_ABORT_EN
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    found = 1'b0;
    for (int k = 0; k < 40 && !found; k++) begin
      @(negedge clk);
      if (a_rd && a_addr == 4'd7) found = 1'b1;
    end
    chk("abort/reached_round3", found, 1);
    @(negedge clk);
    @(negedge clk);
    abort = 1'b1;
    #1;
    chk("abort/st_en_forced", a_st, 0);
    @(negedge clk);
    abort = 1'b0;
    chk("abort/idle_next", a_busy, 0);
    found = 1'b0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (a_done) found = 1'b1;
    end
    chk("abort/no_done", found, 0);
    run_op(0, 1'b0, 60);
    check_op("after_abort", 10, 3, 32);
    idle_check("after_abort");
`endif

    sel = 1'b1;
    run_op(0, 1'b0, 60);
    check_op("nr14", 14, 2, 30);
    idle_check("nr14");

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nbad);
    $finish;
  end

endmodule

// File: doc/decryption_fsm.md
# decryption_fsm

Control FSM for the AES inverse cipher. It sequences the datapath through the initial AddRoundKey, NR-1 full inverse rounds and the final inverse round (InvMixColumns bypassed). Round keys are read from the round-key RAM in reverse order (NR down to 0). It sits beside the key-expansion block and drives the decryption datapath's state-register enable, input mux and InvMixColumns bypass.

## Interface
- NR, 10: number of rounds; legal 10/12/14 (AES-128/192/256).
- CYC_PER_ROUND, 3: cycles per round, >= 2.
- KAW, 4: key address width, >= $clog2(NR+1).

- clk  in  1  clock, rising edge.
- reset_n  in  1  reset, asynchronous, active-low.
- start  in  1  decryption request; sampled only in IDLE.
- key_ready  in  1  round-key RAM holds all NR+1 keys.
- busy  out  1  high in every state except IDLE.
- key_rd_en  out  1  round-key RAM read strobe; data valid 1 cycle later.
- key_addr  out  KAW  round-key index to read.
- ld_sel  out  1  0 = load ciphertext into state register, 1 = load round output.
- st_en  out  1  state register write enable.
- mc_bypass  out  1  1 = skip InvMixColumns (final round).
- done  out  1  one-cycle pulse, plaintext valid in state register.
- abort  in  1  present only with AES_DEC_ABORT_EN.

## Operation
- States: IDLE, KEY_WAIT, INIT_ROUND, MID_ROUND, LAST_ROUND.
- Counters: round_cnt (counts NR down to 0; key_addr = round_cnt), cyc_cnt (CYC_PER_ROUND-1 down to 0).
- IDLE: start & key_ready -> INIT_ROUND; start & !key_ready -> KEY_WAIT; else stay. round_cnt loads NR on exit.
- KEY_WAIT: stay until key_ready=1, then INIT_ROUND. busy=1, no strobes.
- INIT_ROUND (2 cycles): cycle A key_rd_en=1, key_addr=NR; cycle B st_en=1, ld_sel=0. Then round_cnt<=NR-1, cyc_cnt<=CYC_PER_ROUND-1, -> MID_ROUND.
- MID_ROUND: cyc_cnt=CYC_PER_ROUND-1: key_rd_en=1, key_addr=round_cnt. cyc_cnt=0: st_en=1, ld_sel=1, mc_bypass=0; round_cnt decrements; if round_cnt was 1 -> LAST_ROUND, else stay. Other cycles: all strobes 0.
- LAST_ROUND: same cycle pattern with key_addr=0, mc_bypass=1 on every cycle of the state; after cyc_cnt=0 -> IDLE with done=1.
- done is registered; high exactly the first IDLE cycle after LAST_ROUND.
- start while busy: ignored. start in the done cycle: accepted (back-to-back).
- key_ready falling after leaving KEY_WAIT: ignored.
- Outputs outside strobe cycles: key_addr holds last value; ld_sel, mc_bypass 0 except as above.

## Timing
- Reset: state IDLE, round_cnt=NR, cyc_cnt=0; busy, key_rd_en, st_en, ld_sel, mc_bypass, done = 0; key_addr = 0.
- Reset mid-operation: immediate return to IDLE, no done.
- Latency (key_ready=1): edge sampling start = E0; done=1 after edge E(2+NR*CYC_PER_ROUND); NR=10, CYC=3 -> E32. busy high E0..E31 cycles (32 cycles).
- st_en count per operation: exactly NR+1. key_rd_en count: exactly NR+1, addresses NR, NR-1, ..., 0.
- key_rd_en always precedes the matching st_en by CYC_PER_ROUND-1 cycles (1 in INIT_ROUND).

## Configuration
- AES_DEC_ABORT_EN defined: abort port exists; abort=1 in any non-IDLE state forces IDLE on the next edge, st_en and key_rd_en forced 0 in that cycle, done not asserted, counters reload as from reset. abort in IDLE ignored; abort has priority over start.
- Undefined: no abort port; operation always runs to completion.

## Test plan
- Reset then start=1, key_ready=1 (NR=10, CYC=3) -> key_addr reads 10,9,...,0; 11 st_en pulses; first ld_sel=0; mc_bypass only in last round; done pulse after E32.
- start=1, key_ready=0 for 5 cycles then 1 -> KEY_WAIT with busy=1, no strobes; done 5 cycles later than baseline.
- start held high continuously -> second operation starts in done cycle; done pulses 32 cycles apart.
- reset_n low during MID_ROUND round 5 -> all outputs 0 immediately; no done; next start completes normally.
- NR=14, CYC_PER_ROUND=2 -> keys 14..0, done after E30.
- AES_DEC_ABORT_EN: abort=1 in round 3 -> IDLE next edge, no st_en that cycle, no done; new start completes in 32.
